// File: rtl/pipeline_ctrl_if.sv
// Handshake bundle between the pipeline datapath and pipeline_ctrl.
// The master side is the datapath; the slave side is the controller.
interface pipeline_ctrl_if #(
  parameter int unsigned REGS_ADDR_WIDTH = 5,
  parameter int unsigned MULTI_LEN_WIDTH = 6
);
  logic                       id_read_enable1;
  logic [REGS_ADDR_WIDTH-1:0] id_read_addr1;
  logic                       id_read_enable2;
  logic [REGS_ADDR_WIDTH-1:0] id_read_addr2;
  logic                       ex_is_load;
  logic [REGS_ADDR_WIDTH-1:0] ex_write_addr;
  logic                       ex_multi_req;
  logic [MULTI_LEN_WIDTH-1:0] ex_multi_len;
  logic                       flush_req;
  logic [5:0]                 stall;
  logic                       ex_multi_done;
  logic                       flush;

  modport master (
    output id_read_enable1, id_read_addr1, id_read_enable2, id_read_addr2,
    output ex_is_load, ex_write_addr, ex_multi_req, ex_multi_len, flush_req,
    input  stall, ex_multi_done, flush
  );

  modport slave (
    input  id_read_enable1, id_read_addr1, id_read_enable2, id_read_addr2,
    input  ex_is_load, ex_write_addr, ex_multi_req, ex_multi_len, flush_req,
    output stall, ex_multi_done, flush
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Stall/flush controller: load-use hazard detection and multi-cycle EX sequencing.
// Optional PIPELINE_CTRL_STATS_EN adds saturating stall_cycles/flush_count outputs.
module pipeline_ctrl #(
  parameter int unsigned REGS_ADDR_WIDTH = 5,
  parameter int unsigned MULTI_LEN_WIDTH = 6
) (
  input  logic           clock,
  input  logic           reset,
  pipeline_ctrl_if.slave bus
`ifdef PIPELINE_CTRL_STATS_EN
  ,
  output logic [31:0]    stall_cycles,
  output logic [31:0]    flush_count
`endif
);

  typedef enum logic {IDLE, MULTI} state_t;

  localparam logic [5:0] STALL_MULTI = 6'b001111;
  localparam logic [5:0] STALL_LOAD  = 6'b000111;
  localparam logic [MULTI_LEN_WIDTH-1:0] CNT_ONE = MULTI_LEN_WIDTH'(1);

  state_t                     state, state_nx;
  logic [MULTI_LEN_WIDTH-1:0] cnt, cnt_nx;
  logic [5:0]                 stall_c;
  logic                       done_c;
  logic                       flush_c;
  logic                       load_use;

  // Writes to r0 are discarded, so a load targeting r0 never creates a hazard.
  always_comb begin
    load_use = 1'b0;
    if (bus.ex_is_load && (bus.ex_write_addr != {REGS_ADDR_WIDTH{1'b0}})) begin
      load_use = (bus.id_read_enable1 && (bus.id_read_addr1 == bus.ex_write_addr)) ||
                 (bus.id_read_enable2 && (bus.id_read_addr2 == bus.ex_write_addr));
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    stall_c  = '0;
    done_c   = 1'b0;
    flush_c  = 1'b0;
    if (reset) begin
      state_nx = IDLE;
      cnt_nx   = '0;
    end else if (bus.flush_req) begin
      flush_c  = 1'b1;
      state_nx = IDLE;
      cnt_nx   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.ex_multi_req) begin
            if (bus.ex_multi_len > CNT_ONE) begin
              stall_c  = STALL_MULTI;
              state_nx = MULTI;
              cnt_nx   = bus.ex_multi_len - CNT_ONE;
            end else begin
              done_c = 1'b1;
            end
          end else if (load_use) begin
            stall_c = STALL_LOAD;
          end
        end
        MULTI: begin
          if (cnt > CNT_ONE) begin
            stall_c = STALL_MULTI;
            cnt_nx  = cnt - CNT_ONE;
          end else begin
            done_c   = 1'b1;
            state_nx = IDLE;
            cnt_nx   = '0;
          end
        end
        default: begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      endcase
    end
  end

  assign bus.stall         = stall_c;
  assign bus.ex_multi_done = done_c;
  assign bus.flush         = flush_c;

`ifdef PIPELINE_CTRL_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (stall_c[0] && (stall_cycles != '1)) stall_cycles <= stall_cycles + 32'd1;
      if (flush_c && (flush_count != '1))     flush_count  <= flush_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed vectors push expected outputs,
// a negedge monitor pops and compares them.
module tb_pipeline_ctrl;

  typedef struct {
    string      name;
    logic [5:0] stall;
    logic       done;
    logic       flush;
  } exp_t;

  logic clock;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  pipeline_ctrl_if #(.REGS_ADDR_WIDTH(5), .MULTI_LEN_WIDTH(6)) bus ();

`ifdef PIPELINE_CTRL_STATS_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;
`endif

  pipeline_ctrl #(.REGS_ADDR_WIDTH(5), .MULTI_LEN_WIDTH(6)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
`ifdef PIPELINE_CTRL_STATS_EN
    ,
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
`endif
  );

  // Clock starts high so the first negedge samples the time-0 inputs.
  initial clock = 1'b1;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (bus.stall !== e.stall || bus.ex_multi_done !== e.done || bus.flush !== e.flush) begin
        errors++;
        $display("FAIL %s: got stall=%b done=%b flush=%b, expected stall=%b done=%b flush=%b",
                 e.name, bus.stall, bus.ex_multi_done, bus.flush, e.stall, e.done, e.flush);
      end
    end
  end

  task automatic clear_inputs();
    bus.id_read_enable1 = 1'b0;
    bus.id_read_addr1   = '0;
    bus.id_read_enable2 = 1'b0;
    bus.id_read_addr2   = '0;
    bus.ex_is_load      = 1'b0;
    bus.ex_write_addr   = '0;
    bus.ex_multi_req    = 1'b0;
    bus.ex_multi_len    = '0;
    bus.flush_req       = 1'b0;
  endtask

  task automatic set_load_use(input logic [4:0] addr);
    bus.ex_is_load      = 1'b1;
    bus.ex_write_addr   = addr;
    bus.id_read_enable1 = 1'b1;
    bus.id_read_addr1   = addr;
  endtask

  task automatic multi(input logic [5:0] len);
    bus.ex_multi_req = 1'b1;
    bus.ex_multi_len = len;
  endtask

  task automatic step(input string nm, input logic [5:0] st, input logic d, input logic f);
    exp_t e;
    e.name = nm; e.stall = st; e.done = d; e.flush = f;
    sb.push_back(e);
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    clear_inputs();
    // Reset overrides everything.
    reset = 1'b1;
    multi(6'd4); bus.flush_req = 1'b1; set_load_use(5'd3);
    step("reset_forces_zero", 6'b000000, 1'b0, 1'b0);
    step("reset_hold", 6'b000000, 1'b0, 1'b0);
    reset = 1'b0; clear_inputs();
    step("idle_quiet", 6'b000000, 1'b0, 1'b0);

    // Load-use hazard detection.
    set_load_use(5'd3);
    step("load_use_rs1", 6'b000111, 1'b0, 1'b0);
    set_load_use(5'd0);
    step("load_use_r0", 6'b000000, 1'b0, 1'b0);
    clear_inputs();
    bus.ex_is_load = 1'b1; bus.ex_write_addr = 5'd5;
    bus.id_read_enable2 = 1'b1; bus.id_read_addr2 = 5'd5;
    step("load_use_rs2", 6'b000111, 1'b0, 1'b0);
    bus.id_read_enable2 = 1'b0;
    step("load_use_no_enable", 6'b000000, 1'b0, 1'b0);
    clear_inputs(); set_load_use(5'd7); bus.ex_is_load = 1'b0;
    step("no_load_no_hazard", 6'b000000, 1'b0, 1'b0);
    set_load_use(5'd7); bus.id_read_addr1 = 5'd8;
    step("load_addr_differs", 6'b000000, 1'b0, 1'b0);

    // len=4 multi-cycle op; request/len held and a load-use present are ignored in MULTI.
    clear_inputs(); multi(6'd4);
    step("multi4_c0", 6'b001111, 1'b0, 1'b0);
    set_load_use(5'd2);
    step("multi4_c1", 6'b001111, 1'b0, 1'b0);
    step("multi4_c2", 6'b001111, 1'b0, 1'b0);
    step("multi4_done", 6'b000000, 1'b1, 1'b0);
    bus.ex_multi_req = 1'b0;
    step("multi4_idle_after", 6'b000111, 1'b0, 1'b0);

    // Flush aborts MULTI without a done pulse.
    clear_inputs(); multi(6'd4);
    step("flush_m_c0", 6'b001111, 1'b0, 1'b0);
    clear_inputs();
    step("flush_m_c1", 6'b001111, 1'b0, 1'b0);
    bus.flush_req = 1'b1;
    step("flush_m_c2", 6'b000000, 1'b0, 1'b1);
    bus.flush_req = 1'b0; set_load_use(5'd9);
    step("flush_m_idle", 6'b000111, 1'b0, 1'b0);
    clear_inputs();
    step("flush_m_no_done", 6'b000000, 1'b0, 1'b0);

    // Short ops complete immediately.
    multi(6'd1);
    step("len1_done", 6'b000000, 1'b1, 1'b0);
    clear_inputs(); set_load_use(5'd4);
    step("len1_stays_idle", 6'b000111, 1'b0, 1'b0);
    clear_inputs(); multi(6'd0);
    step("len0_done", 6'b000000, 1'b1, 1'b0);

    // len=2 boundary.
    multi(6'd2);
    step("len2_c0", 6'b001111, 1'b0, 1'b0);
    clear_inputs();
    step("len2_done", 6'b000000, 1'b1, 1'b0);

    // Priorities in IDLE.
    multi(6'd3); set_load_use(5'd6); bus.flush_req = 1'b1;
    step("flush_over_all", 6'b000000, 1'b0, 1'b1);
    bus.flush_req = 1'b0; bus.ex_multi_req = 1'b0;
    step("load_use_after_flush", 6'b000111, 1'b0, 1'b0);
    multi(6'd3);
    step("multi_over_load", 6'b001111, 1'b0, 1'b0);
    clear_inputs();
    step("len3_c1", 6'b001111, 1'b0, 1'b0);
    step("len3_done", 6'b000000, 1'b1, 1'b0);

    // Reset mid-MULTI.
    multi(6'd8);
    step("len8_c0", 6'b001111, 1'b0, 1'b0);
    clear_inputs(); reset = 1'b1;
    step("len8_reset", 6'b000000, 1'b0, 1'b0);
    reset = 1'b0;
    step("post_reset_no_done", 6'b000000, 1'b0, 1'b0);
    set_load_use(5'd1);
    step("post_reset_idle", 6'b000111, 1'b0, 1'b0);

`ifdef PIPELINE_CTRL_STATS_EN
    clear_inputs(); reset = 1'b1;
    step("stats_reset", 6'b000000, 1'b0, 1'b0);
    reset = 1'b0;
    checks++;
    if (stall_cycles !== 32'd0 || flush_count !== 32'd0) begin
      errors++;
      $display("FAIL stats_cleared: got stall_cycles=%0d flush_count=%0d, expected 0 and 0",
               stall_cycles, flush_count);
    end
    multi(6'd5);
    step("stats_m5_c0", 6'b001111, 1'b0, 1'b0);
    clear_inputs();
    step("stats_m5_c1", 6'b001111, 1'b0, 1'b0);
    step("stats_m5_c2", 6'b001111, 1'b0, 1'b0);
    step("stats_m5_c3", 6'b001111, 1'b0, 1'b0);
    step("stats_m5_done", 6'b000000, 1'b1, 1'b0);
    set_load_use(5'd11);
    step("stats_lu1", 6'b000111, 1'b0, 1'b0);
    step("stats_lu2", 6'b000111, 1'b0, 1'b0);
    clear_inputs(); bus.flush_req = 1'b1;
    step("stats_flush", 6'b000000, 1'b0, 1'b1);
    clear_inputs();
    checks++;
    if (stall_cycles !== 32'd6) begin
      errors++;
      $display("FAIL stats_stall_cycles: got %0d, expected 6", stall_cycles);
    end
    checks++;
    if (flush_count !== 32'd1) begin
      errors++;
      $display("FAIL stats_flush_count: got %0d, expected 1", flush_count);
    end
`endif

    clear_inputs();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
